// File: rtl/sar_buscador_pkg.sv
// sar_buscador_pkg: shared comparator codes, state encoding and default width for the SAR search controller.
package sar_buscador_pkg;
    localparam int DEF_WIDTH = 4;
    localparam logic [2:0] CMP_GT = 3'b001;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b100;
    typedef enum logic [1:0] {IDLE = 2'd0, TEST = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sar_buscador_if.sv
// sar_buscador_if: control/comparator bundle between the search controller and its surroundings.
interface sar_buscador_if
    import sar_buscador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [2:0]       cmp_result;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] found;
    logic             error;
    modport master (output start, output cmp_result, input guess, input busy, input done, input found, input error);
    modport slave (input start, input cmp_result, output guess, output busy, output done, output found, output error);
endinterface

// File: rtl/sar_buscador.sv
// sar_buscador: successive-approximation search that resolves the comparator's second operand one bit per cycle.
module sar_buscador
    import sar_buscador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic           clk,
    input logic           rst,
    sar_buscador_if.slave bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, guess_q, guess_d, found_q, found_d, new_acc;
    logic [KW-1:0]    k_q, k_d;
    logic             error_q, error_d, is_eq, is_dec;
    assign is_eq = bus.cmp_result == CMP_EQ;
    assign is_dec = (bus.cmp_result == CMP_LT) || (bus.cmp_result == CMP_GT);
    // LT means the trial is still at or below the target, so the trial bit stays set
    assign new_acc = (bus.cmp_result == CMP_LT) ? guess_q : acc_q;
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        guess_d = guess_q;
        found_d = found_q;
        k_d = k_q;
        error_d = error_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = TEST;
                acc_d = '0;
                k_d = KW'(WIDTH - 1);
                guess_d = WIDTH'(1) << (WIDTH - 1);
                error_d = 1'b0;
            end
            TEST: begin
                if (is_eq) begin
                    found_d = guess_q;
                    state_d = DONE;
                end else if (is_dec) begin
                    acc_d = new_acc;
                    if (k_q != '0) begin
                        k_d = k_q - KW'(1);
                        guess_d = new_acc | (WIDTH'(1) << (k_q - KW'(1)));
                    end else begin
                        found_d = new_acc;
                        state_d = DONE;
                    end
                end else begin
                    found_d = guess_q;
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            guess_q <= '0;
            found_q <= '0;
            k_q <= KW'(WIDTH - 1);
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            guess_q <= guess_d;
            found_q <= found_d;
            k_q <= k_d;
            error_q <= error_d;
        end
    end
    assign bus.guess = guess_q;
    assign bus.busy = state_q == TEST;
    assign bus.done = state_q == DONE;
    assign bus.found = found_q;
    assign bus.error = error_q;
endmodule
